// File: rtl/igcn_pkg.sv
// Shared types for the igcn island dispatcher: FSM states, the held request
// fields and the chunk-size helpers.
package igcn_pkg;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, DRAIN, DONE} state_e;

   localparam int unsigned C_MAX_DEF = 32;

   typedef struct packed {
      logic [15:0] size;
      logic        enhanced;
      logic        penalty;
   } chunk_req_t;

   function automatic logic [15:0] max_chunk(input logic enhanced, input int unsigned c_max);
      return enhanced ? 16'(2 * c_max) : 16'(c_max);
   endfunction

   function automatic logic [15:0] chunk_of(input logic [15:0] rem, input logic enhanced,
                                            input int unsigned c_max);
      logic [15:0] mc;
      mc = max_chunk(enhanced, c_max);
      return (rem > mc) ? mc : rem;
   endfunction

endpackage

// File: rtl/igcn_ack_timer.sv
// Accept-wait timer: cleared on each request, counts while waiting, and
// raises a sticky flag once LIMIT waiting cycles have elapsed.
module igcn_ack_timer #(
   parameter int unsigned LIMIT = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned W    = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);
   localparam logic [W-1:0] SAT  = W'(LIMIT);

   logic [W-1:0] cnt_q, cnt_d;
   logic         exp_q, exp_d;

   always_comb begin
      cnt_d = cnt_q;
      exp_d = exp_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         if (cnt_q != SAT) cnt_d = cnt_q + W'(1);
         if (cnt_q == LAST) exp_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         exp_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         exp_q <= exp_d;
      end
   end

   assign expired_o = exp_q;

endmodule

// File: rtl/igcn_island_dispatcher.sv
// Island dispatcher: captures descriptors, splits them into accelerator-legal
// chunks and runs the start/accept handshake with igcn_accelerator.
module igcn_island_dispatcher
   import igcn_pkg::*;
#(
   parameter int unsigned C_MAX       = C_MAX_DEF,
   parameter int unsigned ACK_TIMEOUT = 1024,
   parameter int unsigned STAT_W      = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [15:0]       in_size_i,
   input  logic              in_penalty_i,
   input  logic              in_last_i,
   input  logic              cfg_enhanced_i,
   output logic              start_processing_o,
   output logic [15:0]       island_size_o,
   output logic              strategy_is_enhanced_o,
   output logic              island_needs_penalty_o,
   input  logic              island_accepted_i,
   input  logic              accelerator_busy_i,
   output logic              busy_o,
   output logic              all_done_o,
   output logic              err_timeout_o,
   output logic [STAT_W-1:0] stat_islands_o,
   output logic [STAT_W-1:0] stat_chunks_o
);

   state_e              state_q, state_d;
   chunk_req_t          req_q, req_d;
   logic [15:0]         rem_q, rem_d;
   logic                last_q, last_d;
   logic [STAT_W-1:0]   isl_q, isl_d;
   logic [STAT_W-1:0]   chk_q, chk_d;
   logic [15:0]         rem_left;
   logic                take;

   assign in_ready_o = (state_q == IDLE) || (state_q == DONE);
   assign take       = in_valid_i && in_ready_o;
   // Chunks never exceed what remains, so this cannot wrap.
   assign rem_left   = rem_q - req_q.size;

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      rem_d   = rem_q;
      last_d  = last_q;
      isl_d   = isl_q;
      chk_d   = chk_q;
      case (state_q)
         IDLE, DONE: begin
            if (take) begin
               isl_d  = isl_q + STAT_W'(1);
               last_d = in_last_i;
               rem_d  = in_size_i;
               if (in_size_i == 16'd0) begin
                  state_d = in_last_i ? DRAIN : IDLE;
               end else begin
                  req_d.size     = chunk_of(in_size_i, cfg_enhanced_i, C_MAX);
                  req_d.enhanced = cfg_enhanced_i;
                  req_d.penalty  = in_penalty_i ||
                                   (in_size_i > max_chunk(cfg_enhanced_i, C_MAX));
                  state_d        = ISSUE;
               end
            end
         end
         ISSUE: begin
            chk_d   = chk_q + STAT_W'(1);
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (island_accepted_i) begin
               rem_d = rem_left;
               if (rem_left != 16'd0) begin
                  req_d.size = chunk_of(rem_left, req_q.enhanced, C_MAX);
                  state_d    = ISSUE;
               end else begin
                  state_d = last_q ? DRAIN : IDLE;
               end
            end
         end
         DRAIN: begin
            if (!accelerator_busy_i) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         req_q   <= '0;
         rem_q   <= '0;
         last_q  <= 1'b0;
         isl_q   <= '0;
         chk_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rem_q   <= rem_d;
         last_q  <= last_d;
         isl_q   <= isl_d;
         chk_q   <= chk_d;
      end
   end

   igcn_ack_timer #(.LIMIT(ACK_TIMEOUT)) u_ack_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (state_q == ISSUE),
      .en_i      (state_q == WAIT_ACK),
      .expired_o (err_timeout_o)
   );

   assign start_processing_o     = (state_q == ISSUE);
   assign island_size_o          = req_q.size;
   assign strategy_is_enhanced_o = req_q.enhanced;
   assign island_needs_penalty_o = req_q.penalty;
   assign busy_o                 = (state_q != IDLE) && (state_q != DONE);
   assign all_done_o             = (state_q == DONE);
   assign stat_islands_o         = isl_q;
   assign stat_chunks_o          = chk_q;

endmodule
